// File: rtl/cpu19_mem_pkg.sv
// Shared defaults and state type for the 19-bit CPU memory responder.
// Imported by the interface, the RAM wrapper and the responder top.
package cpu19_mem_pkg;

    localparam int ADDR_W_DEF      = 14;
    localparam int DATA_W_DEF      = 19;
    localparam int DEPTH_DEF       = 4096;
    localparam int WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/cpu19_mem_responder_if.sv
// Request/response channel between the CPU memory port and the responder.
// master = CPU side, slave = responder side.
interface cpu19_mem_responder_if
    import cpu19_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/cpu19_sram_1p.sv
// Synchronous single-port RAM: registered read with one-cycle latency.
// Neither the array nor the read register is reset.
module cpu19_sram_1p #(
    parameter int DATA_W = 19,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu19_mem_responder.sv
// Single-outstanding memory responder: latch request, wait states, RAM access,
// then hold the response until the CPU takes it.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | req_ready high, waiting for a request
//   ST_WAIT   | counting wait states after accept
//   ST_ACCESS | one cycle with RAM enabled; in-range writes commit here
//   ST_RESP   | response valid and held until rsp_valid & rsp_ready
module cpu19_mem_responder
    import cpu19_mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu19_mem_responder_if.slave  bus
);

    localparam int              RAM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rd_sel_q, rd_sel_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              rsp_hs;
    logic              in_range;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;

    assign accept   = bus.req_valid & req_ready_q & (state_q == ST_IDLE);
    assign rsp_hs   = rsp_valid_q & bus.rsp_ready & (state_q == ST_RESP);
    // Full-width compare: out-of-range addresses must never alias into the RAM.
    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign ram_en   = (state_q == ST_ACCESS) & in_range;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rd_sel_d    = rd_sel_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d     = ST_RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = ~in_range;
                rd_sel_d    = in_range & ~we_q;
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rd_sel_d    = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rd_sel_q    <= rd_sel_d;
            busy_q      <= busy_d;
        end
    end

    cpu19_sram_1p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // The RAM read register stays put once the enable drops, so gating it
    // gives a stable response word; writes and errors read back as zero.
    assign bus.rsp_rdata = rd_sel_q ? ram_rdata : '0;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_cpu19_mem_responder.sv
// Bench for cpu19_mem_responder: directed cases plus random traffic, checked
// against an associative-array memory model.
module tb_cpu19_mem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [18:0] ref_mem [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cpu19_mem_responder_if #(.ADDR_W(14), .DATA_W(19)) bus2 ();
    cpu19_mem_responder_if #(.ADDR_W(14), .DATA_W(19)) bus0 ();

    cpu19_mem_responder #(
        .ADDR_W(14), .DATA_W(19), .DEPTH(4096), .WAIT_CYCLES(2)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    cpu19_mem_responder #(
        .ADDR_W(14), .DATA_W(19), .DEPTH(4096), .WAIT_CYCLES(0)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 responder. Called and returns at a negedge.
    task automatic txn2(input logic we, input logic [13:0] addr, input logic [18:0] wdata,
                        input int hold, input bit junk);
        logic [18:0] exp_d;
        logic        exp_e;
        int          lat;
        int          g;
        exp_e = (int'(addr) >= 4096);
        exp_d = 19'd0;
        if (!we && !exp_e) exp_d = ref_mem[int'(addr)];

        bus2.req_valid = 1'b1;
        bus2.req_we    = we;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        g = 0;
        while (!bus2.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk("accept_ready", 32'(bus2.req_ready), 32'd1);
        @(posedge clk);
        if (we && !exp_e) ref_mem[int'(addr)] = wdata;
        @(negedge clk);
        if (!junk) bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 20) begin
            chk("busy_pending", 32'(bus2.busy), 32'd1);
            chk("ready_pending", 32'(bus2.req_ready), 32'd0);
            if (junk) begin
                bus2.req_we    = 1'($urandom);
                bus2.req_addr  = 14'($urandom);
                bus2.req_wdata = 19'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        chk("rsp_rdata", 32'(bus2.rsp_rdata), 32'(exp_d));
        chk("rsp_err", 32'(bus2.rsp_err), 32'(exp_e));
        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                bus2.req_valid = 1'b1;
                bus2.req_we    = 1'b1;
                bus2.req_addr  = 14'($urandom_range(0, 4095));
                bus2.req_wdata = 19'($urandom);
            end
            @(negedge clk);
            chk("hold_valid", 32'(bus2.rsp_valid), 32'd1);
            chk("hold_rdata", 32'(bus2.rsp_rdata), 32'(exp_d));
            chk("hold_err", 32'(bus2.rsp_err), 32'(exp_e));
            chk("hold_ready", 32'(bus2.req_ready), 32'd0);
            chk("hold_busy", 32'(bus2.busy), 32'd1);
        end
        bus2.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus2.req_valid = 1'b0;
        @(negedge clk);
        bus2.rsp_ready = 1'b0;
        chk("post_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("post_err", 32'(bus2.rsp_err), 32'd0);
        chk("post_busy", 32'(bus2.busy), 32'd0);
        chk("post_ready", 32'(bus2.req_ready), 32'd1);
    endtask

    initial begin
        logic [18:0] vals [4];
        logic [13:0] a;
        logic        w;
        int          g, lat, t_acc, t_prev;

        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0;
        bus2.req_wdata = '0;   bus2.rsp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.rsp_ready = 1'b0;
        t_prev = 0;

        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(bus2.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus2.rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(bus2.rsp_err), 32'd0);
        chk("rst_busy", 32'(bus2.busy), 32'd0);
        chk("rst_req_ready0", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_req_ready", 32'(bus2.req_ready), 32'd1);
        chk("rel_req_ready0", 32'(bus0.req_ready), 32'd1);

        // write then read back
        txn2(1'b1, 14'd5, 19'h12345, 0, 1'b0);
        txn2(1'b0, 14'd5, 19'h0, 0, 1'b0);
        // response backpressure with competing requests offered
        txn2(1'b0, 14'd5, 19'h0, 5, 1'b1);
        // out-of-range write must not alias onto 0x0FFF
        txn2(1'b1, 14'h0FFF, 19'h00ABC, 0, 1'b0);
        txn2(1'b1, 14'h3FFF, 19'h7FFFF, 1, 1'b0);
        txn2(1'b0, 14'h0FFF, 19'h0, 0, 1'b0);
        txn2(1'b0, 14'h1000, 19'h0, 0, 1'b0);
        // request inputs wander during WAIT
        txn2(1'b1, 14'd9, 19'h2468A, 0, 1'b1);
        txn2(1'b0, 14'd9, 19'h0, 2, 1'b0);

        // reset during WAIT abandons the write
        txn2(1'b1, 14'd7, 19'h00001, 0, 1'b0);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1;
        bus2.req_addr = 14'd7;  bus2.req_wdata = 19'h55555;
        g = 0;
        while (!bus2.req_ready && g < 20) begin @(negedge clk); g++; end
        chk("t4_accept_ready", 32'(bus2.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("t4_busy_wait", 32'(bus2.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("t4_rst_valid", 32'(bus2.rsp_valid), 32'd0);
        chk("t4_rst_rdata", 32'(bus2.rsp_rdata), 32'd0);
        chk("t4_rst_err", 32'(bus2.rsp_err), 32'd0);
        chk("t4_rst_busy", 32'(bus2.busy), 32'd0);
        chk("t4_rst_ready", 32'(bus2.req_ready), 32'd0);
        bus2.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t4_rel_ready", 32'(bus2.req_ready), 32'd1);
        txn2(1'b0, 14'd7, 19'h0, 0, 1'b0);

        // random traffic: seed a window, then mixed reads/writes/out-of-range
        for (int i = 100; i < 116; i++) txn2(1'b1, 14'(i), 19'($urandom), 0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) a = 14'($urandom_range(4096, 16383));
            else                           a = 14'($urandom_range(100, 115));
            txn2(1'($urandom), a, 19'($urandom), int'($urandom_range(0, 3)),
                 1'($urandom));
        end

        // WAIT_CYCLES=0: back-to-back stream with rsp_ready held high
        for (int k = 0; k < 4; k++) vals[k] = 19'($urandom);
        bus0.rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            w = (k < 4);
            bus0.req_valid = 1'b1;
            bus0.req_we    = w;
            bus0.req_addr  = 14'(k % 4);
            bus0.req_wdata = vals[k % 4];
            g = 0;
            while (!bus0.req_ready && g < 20) begin @(negedge clk); g++; end
            chk("s_ready", 32'(bus0.req_ready), 32'd1);
            @(posedge clk);
            t_acc = cyc;
            if (k > 0) chk("s_interval", 32'(t_acc - t_prev), 32'd3);
            t_prev = t_acc;
            @(negedge clk);
            lat = 1;
            while (!bus0.rsp_valid && lat < 20) begin @(negedge clk); lat++; end
            chk("s_latency", 32'(lat), 32'd2);
            chk("s_rdata", 32'(bus0.rsp_rdata), w ? 32'd0 : 32'(vals[k % 4]));
            chk("s_err", 32'(bus0.rsp_err), 32'd0);
        end
        bus0.req_valid = 1'b0;
        @(negedge clk);
        chk("s_end_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("s_end_busy", 32'(bus0.busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
